// File: rtl/alu_issue_ctrl_if.sv
// Bundle between alu_issue_ctrl, its upstream instruction source and the ALU.
// Handshake: an instruction transfers on a rising edge where instr_valid and instr_ready are both high.
interface alu_issue_ctrl_if;
    logic        instr_valid;
    logic        instr_ready;
    logic [12:0] instr;
    logic [3:0]  alu_a;
    logic [3:0]  alu_b;
    logic [2:0]  alu_opcode;
    logic [3:0]  alu_result;
    logic        alu_carry;
    logic        alu_zero;
    logic        done_valid;
    logic [3:0]  done_result;
    logic        done_illegal;

    modport master (
        output instr_valid, instr, alu_result, alu_carry, alu_zero,
        input  instr_ready, alu_a, alu_b, alu_opcode, done_valid, done_result, done_illegal
    );

    modport slave (
        input  instr_valid, instr, alu_result, alu_carry, alu_zero,
        output instr_ready, alu_a, alu_b, alu_opcode, done_valid, done_result, done_illegal
    );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Three-cycle issue/writeback sequencer around a combinational 4-bit ALU,
// with a 4x4 register file, carry/zero flags and a completion counter.
module alu_issue_ctrl (
    input  logic              clk,
    input  logic              rst,
    alu_issue_ctrl_if.slave   bus,
    input  logic [1:0]        dbg_sel,
    output logic [3:0]        dbg_data,
    output logic              carry_flag,
    output logic              zero_flag,
    output logic [7:0]        instr_count,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic        ready_q, ready_d;
    logic [1:0]  rd_q, rd_d;
    logic [3:0]  imm_q, imm_d;
    logic [3:0]  alu_a_q, alu_a_d;
    logic [3:0]  alu_b_q, alu_b_d;
    logic [2:0]  alu_op_q, alu_op_d;
    logic        done_valid_q, done_valid_d;
    logic [3:0]  done_result_q, done_result_d;
    logic        done_illegal_q, done_illegal_d;
    logic        carry_q, carry_d;
    logic        zero_q, zero_d;
    logic [7:0]  count_q, count_d;
    logic [3:0]  regs_q [4];
    logic [3:0]  regs_d [4];

    logic op_is_alu;
    logic op_is_ldi;

    // The opcode register doubles as the latched op field of the instruction.
    assign op_is_alu = (alu_op_q <= 3'd4);
    assign op_is_ldi = (alu_op_q == 3'b111);

    always_comb begin
        state_d        = state_q;
        ready_d        = ready_q;
        rd_d           = rd_q;
        imm_d          = imm_q;
        alu_a_d        = alu_a_q;
        alu_b_d        = alu_b_q;
        alu_op_d       = alu_op_q;
        done_valid_d   = 1'b0;
        done_result_d  = done_result_q;
        done_illegal_d = done_illegal_q;
        carry_d        = carry_q;
        zero_d         = zero_q;
        count_d        = count_q;
        regs_d         = regs_q;

        case (state_q)
            S_IDLE: begin
                ready_d = 1'b1;
                if (bus.instr_valid && ready_q) begin
                    rd_d     = bus.instr[9:8];
                    imm_d    = bus.instr[3:0];
                    alu_a_d  = regs_q[bus.instr[7:6]];
                    alu_b_d  = regs_q[bus.instr[5:4]];
                    alu_op_d = bus.instr[12:10];
                    ready_d  = 1'b0;
                    state_d  = S_EXEC;
                end
            end
            S_EXEC: begin
                done_valid_d   = 1'b1;
                done_illegal_d = 1'b0;
                state_d        = S_DONE;
                if (op_is_alu) begin
                    regs_d[rd_q]  = bus.alu_result;
                    carry_d       = bus.alu_carry;
                    zero_d        = bus.alu_zero;
                    done_result_d = bus.alu_result;
                end else if (op_is_ldi) begin
                    regs_d[rd_q]  = imm_q;
                    done_result_d = imm_q;
                end else begin
                    done_illegal_d = 1'b1;
                    done_result_d  = 4'd0;
                end
            end
            S_DONE: begin
                count_d = count_q + 8'd1;
                ready_d = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                ready_d = 1'b1;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            ready_q        <= 1'b1;
            rd_q           <= 2'd0;
            imm_q          <= 4'd0;
            alu_a_q        <= 4'd0;
            alu_b_q        <= 4'd0;
            alu_op_q       <= 3'd0;
            done_valid_q   <= 1'b0;
            done_result_q  <= 4'd0;
            done_illegal_q <= 1'b0;
            carry_q        <= 1'b0;
            zero_q         <= 1'b0;
            count_q        <= 8'd0;
            regs_q         <= '{default: 4'd0};
        end else begin
            state_q        <= state_d;
            ready_q        <= ready_d;
            rd_q           <= rd_d;
            imm_q          <= imm_d;
            alu_a_q        <= alu_a_d;
            alu_b_q        <= alu_b_d;
            alu_op_q       <= alu_op_d;
            done_valid_q   <= done_valid_d;
            done_result_q  <= done_result_d;
            done_illegal_q <= done_illegal_d;
            carry_q        <= carry_d;
            zero_q         <= zero_d;
            count_q        <= count_d;
            regs_q         <= regs_d;
        end
    end

    assign bus.instr_ready  = ready_q;
    assign bus.alu_a        = alu_a_q;
    assign bus.alu_b        = alu_b_q;
    assign bus.alu_opcode   = alu_op_q;
    assign bus.done_valid   = done_valid_q;
    assign bus.done_result  = done_result_q;
    assign bus.done_illegal = done_illegal_q;
    assign carry_flag       = carry_q;
    assign zero_flag        = zero_q;
    assign instr_count      = count_q;
    assign dbg_data         = regs_q[dbg_sel];
    assign dbg_state        = state_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl; the bench plays both the instruction source and the ALU.
module tb_alu_issue_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] dbg_sel;
    logic [3:0] dbg_data;
    logic       carry_flag;
    logic       zero_flag;
    logic [7:0] instr_count;
    logic [1:0] dbg_state;

    alu_issue_ctrl_if bus();

    alu_issue_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .dbg_sel     (dbg_sel),
        .dbg_data    (dbg_data),
        .carry_flag  (carry_flag),
        .zero_flag   (zero_flag),
        .instr_count (instr_count),
        .dbg_state   (dbg_state)
    );

    always #5 clk = ~clk;

    int         n_cmp = 0;
    int         n_err = 0;
    int         cyc   = 0;
    int         acc_cyc[$];
    logic [4:0] exp_q[$];
    logic [4:0] sb_e;
    logic [7:0] exp_cnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [12:0] mk(input logic [2:0] op, input logic [1:0] rd,
                                       input logic [1:0] ra, input logic [1:0] rb,
                                       input logic [3:0] imm);
        return {op, rd, ra, rb, imm};
    endfunction

    task automatic chk_dbg(input string tag, input logic [1:0] sel, input logic [3:0] exp);
        dbg_sel = sel;
        #1;
        check(tag, {28'd0, dbg_data}, {28'd0, exp});
    endtask

    // Cycle counter and accept recorder
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst && bus.instr_valid && bus.instr_ready) acc_cyc.push_back(cyc);
    end

    // Scoreboard: every done pulse must match the oldest expected {illegal, result}
    always @(negedge clk) begin
        if (bus.done_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                sb_e = exp_q.pop_front();
                check("done_illegal", {31'd0, bus.done_illegal}, {31'd0, sb_e[4]});
                if (!sb_e[4]) check("done_result", {28'd0, bus.done_result}, {28'd0, sb_e[3:0]});
            end
        end
    end

    task automatic run_instr(input string tag, input logic [12:0] ins, input logic chk_alu,
                             input logic [3:0] ea, input logic [3:0] eb,
                             input logic [3:0] eres, input logic ill);
        logic rdy_seen;
        rdy_seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.instr_ready) begin
                rdy_seen = 1'b1;
                break;
            end
        end
        check({tag, "_ready_wait"}, {31'd0, rdy_seen}, 32'd1);
        if (rdy_seen) begin
            exp_q.push_back({ill, eres});
            bus.instr_valid = 1'b1;
            bus.instr       = ins;
            @(posedge clk);
            #1;
            bus.instr_valid = 1'b0;
            @(negedge clk);
            check({tag, "_exec_ready"}, {31'd0, bus.instr_ready}, 32'd0);
            check({tag, "_exec_dv"}, {31'd0, bus.done_valid}, 32'd0);
            if (chk_alu) begin
                check({tag, "_alu_a"}, {28'd0, bus.alu_a}, {28'd0, ea});
                check({tag, "_alu_b"}, {28'd0, bus.alu_b}, {28'd0, eb});
                check({tag, "_alu_op"}, {29'd0, bus.alu_opcode}, {29'd0, ins[12:10]});
            end
            @(negedge clk);
            check({tag, "_done_dv"}, {31'd0, bus.done_valid}, 32'd1);
            check({tag, "_done_ready"}, {31'd0, bus.instr_ready}, 32'd0);
            if (!ill) chk_dbg({tag, "_rd"}, ins[9:8], eres);
            @(negedge clk);
            exp_cnt = exp_cnt + 8'd1;
            check({tag, "_idle_ready"}, {31'd0, bus.instr_ready}, 32'd1);
            check({tag, "_idle_dv"}, {31'd0, bus.done_valid}, 32'd0);
            check({tag, "_count"}, {24'd0, instr_count}, {24'd0, exp_cnt});
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst             = 1'b1;
        bus.instr_valid = 1'b0;
        bus.instr       = 13'd0;
        bus.alu_result  = 4'd0;
        bus.alu_carry   = 1'b0;
        bus.alu_zero    = 1'b0;
        dbg_sel         = 2'd0;
        exp_cnt         = 8'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        check("rst_ready", {31'd0, bus.instr_ready}, 32'd1);
        check("rst_dv", {31'd0, bus.done_valid}, 32'd0);
        check("rst_dres", {28'd0, bus.done_result}, 32'd0);
        check("rst_dill", {31'd0, bus.done_illegal}, 32'd0);
        check("rst_alu", {21'd0, bus.alu_a, bus.alu_b, bus.alu_opcode}, 32'd0);
        check("rst_flags", {30'd0, carry_flag, zero_flag}, 32'd0);
        check("rst_count", {24'd0, instr_count}, 32'd0);
        check("rst_state", {30'd0, dbg_state}, 32'd0);
        for (int r = 0; r < 4; r++) chk_dbg("rst_reg", r[1:0], 4'd0);

        run_instr("ldi1", mk(3'b111, 2'd1, 2'd0, 2'd0, 4'b0111), 1'b0, 4'd0, 4'd0, 4'b0111, 1'b0);
        run_instr("ldi2", mk(3'b111, 2'd2, 2'd0, 2'd0, 4'b1011), 1'b0, 4'd0, 4'd0, 4'b1011, 1'b0);
        chk_dbg("ldi_r1", 2'd1, 4'b0111);
        chk_dbg("ldi_r2", 2'd2, 4'b1011);
        check("ldi_flags", {30'd0, carry_flag, zero_flag}, 32'd0);
        check("ldi_count", {24'd0, instr_count}, 32'd2);

        bus.alu_result = 4'b0010;
        bus.alu_carry  = 1'b1;
        bus.alu_zero   = 1'b0;
        run_instr("op0", mk(3'b000, 2'd3, 2'd1, 2'd2, 4'd0), 1'b1, 4'b0111, 4'b1011, 4'b0010, 1'b0);
        check("op0_carry", {31'd0, carry_flag}, 32'd1);
        check("op0_zero", {31'd0, zero_flag}, 32'd0);
        chk_dbg("op0_r3", 2'd3, 4'b0010);
        check("op0_hold_a", {28'd0, bus.alu_a}, 32'd7);

        bus.alu_result = 4'b0000;
        bus.alu_carry  = 1'b0;
        bus.alu_zero   = 1'b1;
        run_instr("op3", mk(3'b011, 2'd1, 2'd1, 2'd1, 4'd0), 1'b1, 4'b0111, 4'b0111, 4'b0000, 1'b0);
        check("op3_carry", {31'd0, carry_flag}, 32'd0);
        check("op3_zero", {31'd0, zero_flag}, 32'd1);
        chk_dbg("op3_r1", 2'd1, 4'b0000);

        bus.alu_result = 4'b1111;
        bus.alu_carry  = 1'b1;
        bus.alu_zero   = 1'b0;
        run_instr("ill5", mk(3'b101, 2'd2, 2'd3, 2'd3, 4'd0), 1'b1, 4'b0010, 4'b0010, 4'd0, 1'b1);
        run_instr("ill6", mk(3'b110, 2'd3, 2'd0, 2'd0, 4'hA), 1'b0, 4'd0, 4'd0, 4'd0, 1'b1);
        chk_dbg("ill_r1", 2'd1, 4'b0000);
        chk_dbg("ill_r2", 2'd2, 4'b1011);
        chk_dbg("ill_r3", 2'd3, 4'b0010);
        check("ill_flags", {30'd0, carry_flag, zero_flag}, 32'd1);

        // Four instructions with valid held high: accepts every third cycle
        acc_cyc.delete();
        bus.instr_valid = 1'b1;
        for (int k = 0; k < 12; k++) begin
            if (k > 0) @(negedge clk);
            if (k % 3 == 0) begin
                bus.instr = mk(3'b111, 2'd0, 2'd0, 2'd0, 4'(k / 3 + 1));
                exp_q.push_back({1'b0, 4'(k / 3 + 1)});
            end
            check("b2b_ready", {31'd0, bus.instr_ready}, {31'd0, (k % 3 == 0)});
        end
        @(negedge clk);
        bus.instr_valid = 1'b0;
        exp_cnt = exp_cnt + 8'd4;
        check("b2b_accepts", acc_cyc.size(), 32'd4);
        if (acc_cyc.size() == 4) begin
            for (int i = 1; i < 4; i++) check("b2b_spacing", acc_cyc[i] - acc_cyc[0], 3 * i);
        end
        check("b2b_count", {24'd0, instr_count}, {24'd0, exp_cnt});
        chk_dbg("b2b_r0", 2'd0, 4'd4);
        check("b2b_flags", {30'd0, carry_flag, zero_flag}, 32'd1);

        // Reset during EXEC aborts the instruction
        bus.alu_result  = 4'h5;
        bus.alu_carry   = 1'b1;
        bus.alu_zero    = 1'b0;
        bus.instr_valid = 1'b1;
        bus.instr       = mk(3'b000, 2'd0, 2'd1, 2'd2, 4'd0);
        @(posedge clk);
        #1;
        bus.instr_valid = 1'b0;
        @(negedge clk);
        check("abort_in_exec", {30'd0, dbg_state}, 32'd1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        exp_cnt = 8'd0;
        check("abort_dv", {31'd0, bus.done_valid}, 32'd0);
        check("abort_state", {30'd0, dbg_state}, 32'd0);
        check("abort_flags", {30'd0, carry_flag, zero_flag}, 32'd0);
        check("abort_count", {24'd0, instr_count}, 32'd0);
        for (int r = 0; r < 4; r++) chk_dbg("abort_reg", r[1:0], 4'd0);
        @(negedge clk);
        check("abort_ready", {31'd0, bus.instr_ready}, 32'd1);
        check("abort_dv2", {31'd0, bus.done_valid}, 32'd0);

        // Valid during reset is ignored
        rst             = 1'b1;
        bus.instr_valid = 1'b1;
        bus.instr       = mk(3'b111, 2'd0, 2'd0, 2'd0, 4'hF);
        @(negedge clk);
        rst             = 1'b0;
        bus.instr_valid = 1'b0;
        check("rstv_state", {30'd0, dbg_state}, 32'd0);
        @(negedge clk);
        check("rstv_state2", {30'd0, dbg_state}, 32'd0);
        chk_dbg("rstv_r0", 2'd0, 4'd0);

        // Counter wrap
        for (int i = 0; i < 255; i++)
            run_instr("wrap_ldi", mk(3'b111, 2'd2, 2'd0, 2'd0, 4'(i)), 1'b0, 4'd0, 4'd0, 4'(i), 1'b0);
        check("wrap_255", {24'd0, instr_count}, 32'd255);
        run_instr("wrap_last", mk(3'b111, 2'd2, 2'd0, 2'd0, 4'h9), 1'b0, 4'd0, 4'd0, 4'h9, 1'b0);
        check("wrap_0", {24'd0, instr_count}, 32'd0);

        @(negedge clk);
        check("sb_empty", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/alu_issue_ctrl.md
# alu_issue_ctrl

Issue and writeback controller that sits directly upstream and downstream of the 4-bit ALU. It accepts instructions over a valid/ready handshake and reads operands from an internal 4x4-bit register file. It drives the ALU's A, B and opcode inputs, then writes the ALU's result, carry and zero outputs back into the register file and a flag register. It turns the purely combinational ALU into a sequenced three-cycle execute unit.

## Interface
- No parameters. Data width is fixed at 4 bits, register count at 4, and opcode width at 3 bits to match the ALU.
- One clock; reset is synchronous and active-high.
- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous, active-high reset
- `instr_valid`  in  1  instruction present
- `instr_ready`  out  1  block can accept an instruction
- `instr`  in  13  fields: op[12:10], rd[9:8], ra[7:6], rb[5:4], imm[3:0]
- `alu_a`  out  4  to ALU A
- `alu_b`  out  4  to ALU B
- `alu_opcode`  out  3  to ALU opcode
- `alu_result`  in  4  from ALU result
- `alu_carry`  in  1  from ALU Carry_out
- `alu_zero`  in  1  from ALU zero
- `done_valid`  out  1  one-cycle completion pulse
- `done_result`  out  4  value written to rd (undefined for illegal ops)
- `done_illegal`  out  1  completed instruction had op 101 or 110
- `carry_flag`  out  1  registered carry flag
- `zero_flag`  out  1  registered zero flag
- `instr_count`  out  8  completed-instruction counter
- `dbg_sel`  in  2  debug register select
- `dbg_data`  out  4  combinational read of reg[dbg_sel]

## Operation
- Op classes:
  - op 000–100: ALU ops. Write alu_result to rd, and alu_carry/alu_zero to the flags.
  - op 111: load-immediate. Write imm to rd; flags unchanged.
  - op 101, 110: illegal. No register or flag write; done_illegal=1.
- FSM states are IDLE, EXEC and DONE.
  - IDLE: instr_ready=1. When instr_valid and instr_ready are both high at a rising edge:
    - latch instr;
    - load alu_a←reg[ra], alu_b←reg[rb], alu_opcode←op;
    - go to EXEC.
  - EXEC: instr_ready=0. The ALU settles combinationally. At the closing edge:
    - sample alu_result, alu_carry and alu_zero;
    - perform the write defined for the op class;
    - load done_result;
    - go to DONE.
  - DONE: instr_ready=0, done_valid=1. At the closing edge, instr_count increments and the FSM goes to IDLE.
- Operand selection:
  - ra=rb is legal.
  - rd may equal ra or rb. Operands were captured at accept, so the read-before-write ordering is inherent.
- alu_a, alu_b and alu_opcode hold their last values outside EXEC; they change only at accept.
- instr_count wraps 255→0.
- The block ignores instr_valid while not in IDLE. The upstream block must hold instr stable only while instr_valid=1 and instr_ready=0; the payload is sampled at the accept edge only.

## Timing
- Reset values:
  - state=IDLE, instr_ready=1;
  - all registers 0; alu_a, alu_b, alu_opcode = 0;
  - done_valid=0, done_result=0, done_illegal=0;
  - carry_flag=0, zero_flag=0, instr_count=0.
- Latency from the accept edge (cycle 0):
  - EXEC in cycle 1;
  - register and flag write at the end of cycle 1;
  - done_valid high in cycle 2;
  - instr_ready high again in cycle 3.
- Throughput: one instruction per 3 cycles. Back-to-back valid gives accepts at cycles 0, 3, 6, …
- dbg_data reflects a write from the cycle following the write edge, i.e. during DONE.
- Reset asserted in EXEC or DONE aborts the instruction: no write, no count increment, done_valid=0 next cycle, state=IDLE. Reset has priority over every other event.
- instr_valid asserted in the same cycle that rst is high is not accepted.

## Test plan
- Reset, then LDI r1←0111 and LDI r2←1011:
  - dbg_data(r1)=0111 and dbg_data(r2)=1011;
  - flags stay 0;
  - instr_count=2;
  - each done_valid is one cycle, 2 cycles after accept.
- ALU op 000 with rd=r3, ra=r1, rb=r2:
  - in EXEC, alu_a=0111, alu_b=1011, alu_opcode=000;
  - the stub returns result 0010, carry 1, zero 0;
  - expect r3=0010, carry_flag=1, zero_flag=0, done_result=0010.
- Op 011 with rd=r1, ra=r1, rb=r1, stub returning 0000/0/1:
  - alu_a=alu_b=0111;
  - r1=0000, zero_flag=1, carry_flag=0.
- Illegal op 101:
  - done_illegal=1 in DONE;
  - registers and flags unchanged;
  - instr_count increments.
- instr_valid held high for 4 instructions:
  - accepts occur exactly at cycles 0, 3, 6, 9;
  - instr_ready is low in EXEC and DONE.
- rst pulsed during EXEC of an ALU op:
  - no done_valid;
  - all registers, flags and instr_count = 0;
  - instr_ready=1 the cycle after reset deasserts.
- Run 256 LDIs: instr_count wraps to 0.
